conv3x3_sr_unit: RTL and testbench

CONV3X3_SR_UNIT -- requirements
Module: conv3x3_sr_unit

---
 rtl/conv3x3_sr_unit_if.sv | 25 ++
 rtl/conv3x3_sr_unit.sv | 108 ++++++++++
 tb/tb_conv3x3_sr_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_sr_unit_if.sv
// Purpose: stream bundle for conv3x3_sr_unit (pixels and weights in, results out).
// Latency: none, wiring only.
// Backpressure: none, valid-only streams that the sink must accept every cycle.
// Ports: data_in/data_valid pixel stream, weight_in/weight_valid coefficient stream,
//        data_out/out_valid result stream. master = source side, slave = the unit.
interface conv3x3_sr_unit_if #(
    parameter int WIDTH = 9
);
    logic [WIDTH-1:0]     data_in;
    logic                 data_valid;
    logic [WIDTH-1:0]     weight_in;
    logic                 weight_valid;
    logic [2*WIDTH+3:0]   data_out;
    logic                 out_valid;

    modport master (
        output data_in, data_valid, weight_in, weight_valid,
        input  data_out, out_valid
    );

    modport slave (
        input  data_in, data_valid, weight_in, weight_valid,
        output data_out, out_valid
    );
endinterface

// File: rtl/conv3x3_sr_unit.sv
// Purpose: 3x3 signed correlation over a raster pixel stream using a shift-register line buffer.
// Latency: result appears 2 edges after the pixel that completes its window.
// Backpressure: none; pixels and weights are taken whenever their valid is high.
// Ports: clk, rst_n (synchronous, active-HIGH despite the name), bus (slave modport):
//        data_in/data_valid pixels, weight_in/weight_valid kernel, data_out/out_valid results.
module conv3x3_sr_unit #(
    parameter int WIDTH = 9,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    conv3x3_sr_unit_if.slave   bus
);
    localparam int LB_LEN = 2 * IMG_W + 3;
    localparam int PW     = 2 * WIDTH;
    localparam int SW     = 2 * WIDTH + 4;
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic signed [WIDTH-1:0] lb   [LB_LEN];
    logic signed [WIDTH-1:0] wt   [9];
    logic signed [WIDTH-1:0] win  [9];
    logic signed [PW-1:0]    prod [9];
    logic        [3:0]       wt_idx;
    logic        [CW-1:0]    col;
    logic        [RW-1:0]    row;
    logic                    win_vld;
    logic                    prd_vld;
    logic                    out_vld_q;
    logic signed [SW-1:0]    sum_c;
    logic signed [SW-1:0]    dout_q;

    // Kernel registers, row-major b00..b22; index wraps 8 -> 0 so a new set of
    // nine simply overwrites the previous one.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 9; i++) wt[i] <= '0;
            wt_idx <= '0;
        end else if (bus.weight_valid) begin
            wt[wt_idx] <= $signed(bus.weight_in);
            wt_idx     <= (wt_idx == 4'd8) ? 4'd0 : wt_idx + 4'd1;
        end
    end

    // Line buffer and raster position. lb[0] is the newest pixel; everything
    // freezes while no pixel is offered. win_vld tags the pixel that completes
    // a window lying entirely inside the current frame rows/cols.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < LB_LEN; i++) lb[i] <= '0;
            col     <= '0;
            row     <= '0;
            win_vld <= 1'b0;
        end else begin
            win_vld <= bus.data_valid && (col >= CW'(2)) && (row >= RW'(2));
            if (bus.data_valid) begin
                lb[0] <= $signed(bus.data_in);
                for (int i = 1; i < LB_LEN; i++) lb[i] <= lb[i-1];
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Window taps: a_rc sits (2-r) rows and (2-c) columns behind the newest pixel.
    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign win[r*3+c] = lb[(2-r)*IMG_W + (2-c)];
        end
    end

    // Stage 1: products. Only the tagged window is worth registering; the
    // operands are sign-extended first so the product is exact.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 9; i++) prod[i] <= '0;
        end else if (win_vld) begin
            for (int i = 0; i < 9; i++) prod[i] <= PW'(win[i]) * PW'(wt[i]);
        end
    end

    // Nine 2W-bit terms need at most 4 extra bits, so the sum cannot wrap.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 9; i++) sum_c = sum_c + SW'(prod[i]);
    end

    // Stage 2: tags advance every cycle; data_out only changes on a result.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            prd_vld   <= 1'b0;
            out_vld_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            prd_vld   <= win_vld;
            out_vld_q <= prd_vld;
            if (prd_vld) dout_q <= sum_c;
        end
    end

    assign bus.data_out  = dout_q;
    assign bus.out_valid = out_vld_q;
endmodule

// File: tb/tb_conv3x3_sr_unit.sv
module tb_conv3x3_sr_unit;
    localparam int WIDTH = 9;
    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int NRES  = (IMG_W - 2) * (IMG_H - 2);

    typedef struct packed {
        longint val;
        int     cyc;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv3x3_sr_unit_if #(.WIDTH(WIDTH)) bus ();

    conv3x3_sr_unit #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t obs_q[$];

    // Reference model state: image as a 2D array, kernel as 9 ints.
    int m_img[IMG_H][IMG_W];
    int m_w[9];
    int m_widx, m_row, m_col;

    // Recorder only: logs every result with the edge number it appeared after.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (bus.out_valid === 1'b1)
            obs_q.push_back('{val: longint'($signed(bus.data_out)), cyc: cyc});
    end

    function automatic void model_reset();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) m_img[r][c] = 0;
        for (int i = 0; i < 9; i++) m_w[i] = 0;
        m_widx = 0;
        m_row  = 0;
        m_col  = 0;
    endfunction

    function automatic int rnd_val();
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    // Drive one edge's worth of inputs and advance the model to match.
    task automatic tick(input logic dv, input int px, input logic wv, input int w, input logic rst);
        int   edge_n;
        int   acc;
        res_t keep[$];
        @(negedge clk);
        rst_n            = rst;
        bus.data_valid   = dv;
        bus.data_in      = WIDTH'(px);
        bus.weight_valid = wv;
        bus.weight_in    = WIDTH'(w);
        edge_n = cyc + 1;
        if (rst) begin
            foreach (exp_q[i]) if (exp_q[i].cyc < edge_n) keep.push_back(exp_q[i]);
            exp_q = keep;
            model_reset();
        end else begin
            if (wv) begin
                m_w[m_widx] = w;
                m_widx = (m_widx == 8) ? 0 : m_widx + 1;
            end
            if (dv) begin
                m_img[m_row][m_col] = px;
                if (m_row >= 2 && m_col >= 2) begin
                    acc = 0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            acc += m_img[m_row-2+i][m_col-2+j] * m_w[i*3+j];
                    exp_q.push_back('{val: longint'(acc), cyc: edge_n + 2});
                end
                m_col++;
                if (m_col == IMG_W) begin
                    m_col = 0;
                    m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
                end
            end
        end
    endtask

    task automatic do_reset();
        tick(1'b1, rnd_val(), 1'b1, rnd_val(), 1'b1);
        tick(1'b1, rnd_val(), 1'b1, rnd_val(), 1'b1);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, rnd_val(), 1'b0, 0, 1'b0);
    endtask

    task automatic load_weights_rand();
        for (int i = 0; i < 9; i++) tick(1'b0, rnd_val(), 1'b1, rnd_val(), 1'b0);
    endtask

    task automatic test_reset();
        // Leave the unit mid-frame with a partial weight index and results in flight.
        for (int i = 0; i < 25; i++) tick(1'b1, rnd_val(), i % 2 == 0, rnd_val(), 1'b0);
        tick(1'b1, rnd_val(), 1'b1, rnd_val(), 1'b1);
        tick(1'b1, rnd_val(), 1'b1, rnd_val(), 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.data_out !== '0) begin
            errors++;
            $display("FAIL reset_data_out: got %0d want 0", $signed(bus.data_out));
        end
        exp_q.delete();
        obs_q.delete();
        load_weights_rand();
        for (int i = 0; i < IMG_W * IMG_H; i++) tick(1'b1, rnd_val(), 1'b0, 0, 1'b0);
        idle(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL reset_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_result[%0d]: got %0d@%0d want %0d@%0d",
                         i, obs_q[i].val, obs_q[i].cyc, exp_q[i].val, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_all_ones();
        do_reset();
        for (int i = 0; i < 9; i++) tick(1'b0, 0, 1'b1, 1, 1'b0);
        for (int i = 0; i < IMG_W * IMG_H; i++) tick(1'b1, 1, 1'b0, 0, 1'b0);
        idle(4);
        checks++;
        if (obs_q.size() !== NRES) begin
            errors++;
            $display("FAIL ones_count: got %0d want %0d", obs_q.size(), NRES);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].val !== 64'sd9 || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ones_result[%0d]: got %0d@%0d want 9@%0d",
                         i, obs_q[i].val, obs_q[i].cyc, exp_q[i].cyc);
            end
        end
    endtask

    task automatic load_identity();
        for (int i = 0; i < 9; i++) tick(1'b0, 0, 1'b1, (i == 4) ? 1 : 0, 1'b0);
    endtask

    task automatic test_identity();
        int want;
        do_reset();
        load_identity();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) tick(1'b1, r * IMG_W + c, 1'b0, 0, 1'b0);
        idle(4);
        checks++;
        if (obs_q.size() !== NRES) begin
            errors++;
            $display("FAIL ident_count: got %0d want %0d", obs_q.size(), NRES);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            want = (2 + i / (IMG_W - 2) - 1) * IMG_W + (2 + i % (IMG_W - 2) - 1);
            checks++;
            if (obs_q[i].val !== longint'(want) || obs_q[i].cyc !== exp_q[i].cyc) begin
                errors++;
                $display("FAIL ident_result[%0d]: got %0d@%0d want %0d@%0d",
                         i, obs_q[i].val, obs_q[i].cyc, want, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_signed_extreme();
        do_reset();
        for (int i = 0; i < 9; i++) tick(1'b0, 0, 1'b1, -256, 1'b0);
        for (int i = 0; i < IMG_W * IMG_H; i++) tick(1'b1, -256, 1'b0, 0, 1'b0);
        idle(4);
        checks++;
        if (obs_q.size() !== NRES) begin
            errors++;
            $display("FAIL extreme_count: got %0d want %0d", obs_q.size(), NRES);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].val !== 64'sd589824 || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL extreme_result[%0d]: got %0d@%0d want 589824@%0d",
                         i, obs_q[i].val, obs_q[i].cyc, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_bubbles();
        int want;
        do_reset();
        load_identity();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
                tick(1'b1, r * IMG_W + c, 1'b0, 0, 1'b0);
            end
        idle(4);
        checks++;
        if (obs_q.size() !== NRES) begin
            errors++;
            $display("FAIL bubble_count: got %0d want %0d", obs_q.size(), NRES);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            want = (2 + i / (IMG_W - 2) - 1) * IMG_W + (2 + i % (IMG_W - 2) - 1);
            checks++;
            if (obs_q[i].val !== longint'(want) || obs_q[i].cyc !== exp_q[i].cyc) begin
                errors++;
                $display("FAIL bubble_result[%0d]: got %0d@%0d want %0d@%0d",
                         i, obs_q[i].val, obs_q[i].cyc, want, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_mid_reset();
        int pre;
        do_reset();
        load_weights_rand();
        for (int i = 0; i < 30; i++) tick(1'b1, rnd_val(), 1'b0, 0, 1'b0);
        tick(1'b1, rnd_val(), 1'b1, rnd_val(), 1'b1);
        tick(1'b0, rnd_val(), 1'b0, 0, 1'b1);
        pre = exp_q.size();
        load_weights_rand();
        for (int i = 0; i < IMG_W * IMG_H; i++) tick(1'b1, rnd_val(), 1'b0, 0, 1'b0);
        idle(4);
        checks++;
        if (exp_q.size() - pre !== NRES || obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL midrst_count: got %0d want %0d (post-reset want %0d)",
                     obs_q.size(), exp_q.size(), NRES);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midrst_result[%0d]: got %0d@%0d want %0d@%0d",
                         i, obs_q[i].val, obs_q[i].cyc, exp_q[i].val, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_weights_rand();
        // Two frames with no gap; kernel coefficients change under the stream.
        for (int i = 0; i < 2 * IMG_W * IMG_H; i++)
            tick(1'b1, rnd_val(), $urandom_range(0, 3) == 0, rnd_val(), 1'b0);
        idle(6);
        checks++;
        if (obs_q.size() !== 2 * NRES || exp_q.size() !== 2 * NRES) begin
            errors++;
            $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), 2 * NRES);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got %0d@%0d want %0d@%0d",
                         i, obs_q[i].val, obs_q[i].cyc, exp_q[i].val, exp_q[i].cyc);
            end
        end
        if (exp_q.size() > 0) begin
            checks++;
            if (bus.out_valid !== 1'b0 ||
                longint'($signed(bus.data_out)) !== exp_q[exp_q.size()-1].val) begin
                errors++;
                $display("FAIL b2b_hold: got %0d (vld %b) want %0d (vld 0)",
                         $signed(bus.data_out), bus.out_valid, exp_q[exp_q.size()-1].val);
            end
        end
    endtask

    initial begin
        bus.data_in      = '0;
        bus.data_valid   = 1'b0;
        bus.weight_in    = '0;
        bus.weight_valid = 1'b0;
        model_reset();
        test_reset();
        test_all_ones();
        test_identity();
        test_signed_extreme();
        test_bubbles();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
